// File: rtl/arm_ctrl_pkg.sv
// Shared types and encodings for the ARM-subset multicycle controller.
// State names, ALU ops, condition codes, opcodes and mux selects.
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    EXECR,
    EXECI,
    ALUWB,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    BRANCH
  } state_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_MOV = 2'b11;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [1:0] IMM8  = 2'b00;
  localparam logic [1:0] IMM12 = 2'b01;
  localparam logic [1:0] IMM24 = 2'b10;

  localparam logic [1:0] SRCB_RM  = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_4   = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  function automatic logic cmd_ok(
    input logic [3:0] c
  );
    return (c == CMD_ADD) || (c == CMD_SUB) ||
           (c == CMD_CMP) || (c == CMD_MOV);
  endfunction

  function automatic logic [1:0] alu_op(
    input logic [3:0] c
  );
    logic [1:0] r;
    r = ALU_ADD;
    unique case (1'b1)
      (c == CMD_SUB): r = ALU_SUB;
      (c == CMD_CMP): r = ALU_SUB;
      (c == CMD_MOV): r = ALU_MOV;
      default:        r = ALU_ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/arm_multicycle_ctrl_cond.sv
// Condition check: instruction cond field against registered NZCV.
// Unknown condition codes never execute.
module arm_cond_unit
  import arm_ctrl_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       cond_ok_o
);

  logic z;
  assign z = flags_i[2];

  always_comb begin
    cond_ok_o = 1'b0;
    unique case (1'b1)
      (cond_i == COND_EQ): cond_ok_o = z;
      (cond_i == COND_NE): cond_ok_o = ~z;
      (cond_i == COND_AL): cond_ok_o = 1'b1;
      default:             cond_ok_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/arm_multicycle_ctrl.sv
// Multicycle sequencer for the ARM-subset datapath.
// Owns state, NZCV flags and all datapath control decodes.
module arm_multicycle_ctrl
  import arm_ctrl_pkg::*;
#(
  parameter logic [3:0] LR_IDX = 4'd14,
  parameter logic [3:0] PC_IDX = 4'd15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cond,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  input  logic [3:0] alu_flags,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       link_sel,
  output logic [1:0] result_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_control,
  output logic [1:0] imm_src,
  output logic [1:0] reg_src,
  output logic [3:0] flags,
  output logic       illegal
);

  state_e     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       cond_ok;
  logic [3:0] cmd;
  logic       ibit, sbit, lbit, link;
  logic       rd_pc;

  assign cmd   = funct[4:1];
  assign ibit  = funct[5];
  assign sbit  = funct[0];
  assign lbit  = funct[0];
  assign link  = funct[4];
  assign rd_pc = (rd == PC_IDX);
  assign flags = flags_q;

  arm_cond_unit u_cond (
    .cond_i    (cond),
    .flags_i   (flags_q),
    .cond_ok_o (cond_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flags_d     = flags_q;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    link_sel    = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_RM;
    alu_control = ALU_ADD;
    imm_src     = IMM8;
    reg_src     = 2'b00;
    illegal     = 1'b0;

    unique case (state_q)
      FETCH: begin
        mem_req    = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_4;
        result_src = RES_ALU;
        // IR/PC must load once per fetch, not every wait cycle
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM24;
        state_d   = FETCH;
        if (cond_ok) begin
          unique case (1'b1)
            (op == OP_DP && cmd_ok(cmd)):
              state_d = ibit ? EXECI : EXECR;
            (op == OP_DP && !cmd_ok(cmd)):
              illegal = 1'b1;
            (op == OP_MEM):
              state_d = MEMADR;
            (op == OP_BR):
              state_d = BRANCH;
            default:
              illegal = 1'b1;
          endcase
        end
      end
      EXECR, EXECI: begin
        alu_src_b   = (state_q == EXECI) ? SRCB_IMM
                                         : SRCB_RM;
        imm_src     = IMM8;
        alu_control = alu_op(cmd);
        if (sbit || cmd == CMD_CMP)
          flags_d = alu_flags;
        state_d = (cmd == CMD_CMP) ? FETCH : ALUWB;
      end
      ALUWB: begin
        result_src = RES_ALUOUT;
        pc_write   = rd_pc;
        reg_write  = ~rd_pc;
        state_d    = FETCH;
      end
      MEMADR: begin
        alu_src_b = SRCB_IMM;
        imm_src   = IMM12;
        state_d   = lbit ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready)
          state_d = MEMWB;
      end
      MEMWB: begin
        result_src = RES_MEM;
        pc_write   = rd_pc;
        reg_write  = ~rd_pc;
        state_d    = FETCH;
      end
      MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        reg_src   = 2'b10;
        if (mem_ready)
          state_d = FETCH;
      end
      BRANCH: begin
        pc_write   = 1'b1;
        result_src = RES_ALUOUT;
        if (link) begin
          link_sel  = 1'b1;
          // a link into the PC slot would clobber the branch target
          reg_write = (LR_IDX != PC_IDX);
        end
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    if (!rst_n) begin
      mem_req     = 1'b0;
      mem_write   = 1'b0;
      adr_src     = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      reg_write   = 1'b0;
      link_sel    = 1'b0;
      result_src  = RES_ALUOUT;
      alu_src_a   = 1'b0;
      alu_src_b   = SRCB_RM;
      alu_control = ALU_ADD;
      imm_src     = IMM8;
      reg_src     = 2'b00;
      illegal     = 1'b0;
    end
  end

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Directed bench for arm_multicycle_ctrl.
// Enables are packed into one byte and checked per cycle.
module tb_arm_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] alu_flags;
  logic       mem_ready;
  logic       mem_req, mem_write, adr_src;
  logic       ir_write, pc_write, reg_write;
  logic       link_sel, alu_src_a, illegal;
  logic [1:0] result_src, alu_src_b;
  logic [1:0] alu_control, imm_src, reg_src;
  logic [3:0] flags;

  int total = 0;
  int bad   = 0;

  logic [7:0] en;
  assign en = {mem_req, mem_write, adr_src,
               ir_write, pc_write, reg_write,
               link_sel, illegal};

  always #5 clk = ~clk;

  arm_multicycle_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cond        (cond),
    .op          (op),
    .funct       (funct),
    .rd          (rd),
    .alu_flags   (alu_flags),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_write   (mem_write),
    .adr_src     (adr_src),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .reg_write   (reg_write),
    .link_sel    (link_sel),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_control (alu_control),
    .imm_src     (imm_src),
    .reg_src     (reg_src),
    .flags       (flags),
    .illegal     (illegal)
  );

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h",
             tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [3:0] c,
                       input logic [1:0] o,
                       input logic [5:0] f,
                       input logic [3:0] r);
    cond  = c;
    op    = o;
    funct = f;
    rd    = r;
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    alu_flags = 4'h0;
    instr(4'he, 2'd0, 6'b001000, 4'd1);
    repeat (2) @(negedge clk);
    chk("rst_en", en, 8'h00);
    chk("rst_flags", {4'h0, flags}, 8'h00);
    rst_n = 1'b1;
    #1;
    chk("f_en", en, 8'h98);
    chk("f_srcb", {6'd0, alu_src_b}, 8'h02);
    chk("f_res", {6'd0, result_src}, 8'h02);
    chk("f_srca", {7'd0, alu_src_a}, 8'h01);

    // ADD R1,R2,R3
    step();
    chk("add_dec_en", en, 8'h00);
    chk("add_dec_imm", {6'd0, imm_src}, 8'h02);
    chk("add_dec_srcb", {6'd0, alu_src_b}, 8'h01);
    step();
    chk("add_ex_en", en, 8'h00);
    chk("add_ex_srca", {7'd0, alu_src_a}, 8'h00);
    chk("add_ex_srcb", {6'd0, alu_src_b}, 8'h00);
    chk("add_ex_alu", {6'd0, alu_control}, 8'h00);
    step();
    chk("add_wb_en", en, 8'h04);
    chk("add_wb_res", {6'd0, result_src}, 8'h00);
    step();
    chk("add_fetch", en, 8'h98);

    // CMP sets Z
    instr(4'he, 2'd0, 6'b010100, 4'd0);
    alu_flags = 4'b0100;
    step();
    chk("cmp_dec", en, 8'h00);
    step();
    chk("cmp_ex_en", en, 8'h00);
    chk("cmp_ex_alu", {6'd0, alu_control}, 8'h01);
    step();
    chk("cmp_fetch", en, 8'h98);
    chk("cmp_flags", {4'h0, flags}, 8'h04);

    // BEQ taken
    instr(4'h0, 2'd2, 6'b000000, 4'd0);
    alu_flags = 4'hf;
    step();
    chk("beq_dec", en, 8'h00);
    step();
    chk("beq_br_en", en, 8'h08);
    chk("beq_br_res", {6'd0, result_src}, 8'h00);
    step();
    chk("beq_fetch", en, 8'h98);
    chk("beq_flags", {4'h0, flags}, 8'h04);

    // BNE not taken
    instr(4'h1, 2'd2, 6'b000000, 4'd0);
    step();
    chk("bne_dec", en, 8'h00);
    step();
    chk("bne_fetch", en, 8'h98);

    // LDR with 3 wait cycles
    instr(4'he, 2'd1, 6'b000001, 4'd2);
    step();
    chk("ldr_dec", en, 8'h00);
    step();
    chk("ldr_ma_en", en, 8'h00);
    chk("ldr_ma_imm", {6'd0, imm_src}, 8'h01);
    chk("ldr_ma_srcb", {6'd0, alu_src_b}, 8'h01);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ldr_rd_wait", en, 8'ha0);
    end
    mem_ready = 1'b1;
    #1;
    chk("ldr_rd_last", en, 8'ha0);
    step();
    chk("ldr_wb_en", en, 8'h04);
    chk("ldr_wb_res", {6'd0, result_src}, 8'h01);
    step();
    chk("ldr_fetch", en, 8'h98);

    // BL
    instr(4'he, 2'd2, 6'b010000, 4'd0);
    step();
    chk("bl_dec", en, 8'h00);
    step();
    chk("bl_br", en, 8'h0e);
    step();
    chk("bl_fetch", en, 8'h98);

    // op=11 illegal
    instr(4'he, 2'd3, 6'b000000, 4'd0);
    step();
    chk("op3_dec", en, 8'h01);
    step();
    chk("op3_fetch", en, 8'h98);

    // unsupported cmd
    instr(4'he, 2'd0, 6'b000000, 4'd0);
    step();
    chk("cmd_dec", en, 8'h01);
    step();
    chk("cmd_fetch", en, 8'h98);

    // MOVS PC,#imm
    instr(4'he, 2'd0, 6'b111011, 4'd15);
    alu_flags = 4'b1000;
    step();
    step();
    chk("mov_ex_alu", {6'd0, alu_control}, 8'h03);
    chk("mov_ex_srcb", {6'd0, alu_src_b}, 8'h01);
    chk("mov_ex_imm", {6'd0, imm_src}, 8'h00);
    step();
    chk("mov_wb_pc", en, 8'h08);
    step();
    chk("mov_fetch", en, 8'h98);
    chk("mov_flags", {4'h0, flags}, 8'h08);

    // BEQ not taken, Z=0
    instr(4'h0, 2'd2, 6'b000000, 4'd0);
    step();
    chk("beq2_dec", en, 8'h00);
    step();
    chk("beq2_fetch", en, 8'h98);

    // STR, reset during wait
    instr(4'he, 2'd1, 6'b000000, 4'd3);
    step();
    step();
    mem_ready = 1'b0;
    step();
    chk("str_wr_en", en, 8'he0);
    chk("str_wr_rsrc", {6'd0, reg_src}, 8'h02);
    step();
    chk("str_wr_hold", en, 8'he0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("str_rst_en", en, 8'h00);
    chk("str_rst_flags", {4'h0, flags}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_f", en, 8'h80);
    mem_ready = 1'b1;
    #1;
    chk("post_rst_rdy", en, 8'h98);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
